// File: rtl/tube_r3_dma_ctrl.sv
// rtl/tube_r3_dma_ctrl.sv - DRQ-paced block mover between parasite memory and Tube register 3.
// Two-byte bursts following the Tube V flag are enabled by defining TUBE_DMA_TWO_BYTE_EN.
module tube_r3_dma_ctrl #(
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              h_rst_b,
   input  logic              start,
   input  logic              dir,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              abort,
   input  logic              drq,
   input  logic              two_byte_mode,
   output logic              tube_cs_b,
   output logic [2:0]        tube_addr,
   output logic              tube_rdnw,
   output logic [7:0]        tube_wdata,
   input  logic [7:0]        tube_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [LEN_W-1:0]  remaining
);

   typedef enum logic [2:0] {
      IDLE, WAIT_DRQ, MEM_RD, TUBE_WR, TUBE_RD, MEM_WR, SETTLE, FINISH
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  cnt_q;
   logic              dir_q;
   logic [7:0]        buf_q;
   logic [1:0]        burst_q;
   logic [1:0]        burst_init;
   logic              byte_done;
   logic              last_byte;
   logic              more_in_burst;

`ifdef TUBE_DMA_TWO_BYTE_EN
   assign burst_init = two_byte_mode ? 2'd2 : 2'd1;
`else
   logic unused_two_byte;
   assign unused_two_byte = two_byte_mode;
   assign burst_init      = 2'd1;
`endif

   // Address, data and count outputs come straight from holding registers.
   assign tube_addr  = 3'h5;
   assign tube_wdata = buf_q;
   assign mem_wdata  = buf_q;
   assign mem_addr   = addr_q;
   assign remaining  = cnt_q;

   assign byte_done     = (state == TUBE_WR) || (state == MEM_WR && mem_ack);
   assign last_byte     = (cnt_q == LEN_W'(1));
   assign more_in_burst = (burst_q > 2'd1);

   always_ff @(posedge clk or negedge h_rst_b) begin
      if (!h_rst_b) begin
         state     <= IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         buf_q     <= 8'h00;
         burst_q   <= 2'd0;
         tube_cs_b <= 1'b1;
         tube_rdnw <= 1'b1;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (length == '0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     addr_q  <= start_addr;
                     cnt_q   <= length;
                     dir_q   <= dir;
                     burst_q <= burst_init;
                     state   <= WAIT_DRQ;
                  end
               end
            end
            WAIT_DRQ: begin
               if (abort) begin
                  state   <= FINISH;
                  done    <= 1'b1;
                  aborted <= 1'b1;
               end else if (drq) begin
                  if (!dir_q) begin
                     state   <= MEM_RD;
                     mem_req <= 1'b1;
                     mem_we  <= 1'b0;
                  end else begin
                     state     <= TUBE_RD;
                     tube_cs_b <= 1'b0;
                     tube_rdnw <= 1'b1;
                  end
               end
            end
            MEM_RD: begin
               if (mem_ack) begin
                  buf_q     <= mem_rdata;
                  mem_req   <= 1'b0;
                  tube_cs_b <= 1'b0;
                  tube_rdnw <= 1'b0;
                  state     <= TUBE_WR;
               end
            end
            TUBE_WR: begin
               tube_cs_b <= 1'b1;
               tube_rdnw <= 1'b1;
            end
            TUBE_RD: begin
               buf_q     <= tube_rdata;
               tube_cs_b <= 1'b1;
               mem_req   <= 1'b1;
               mem_we    <= 1'b1;
               state     <= MEM_WR;
            end
            MEM_WR: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            end
            SETTLE: begin
               burst_q <= burst_init;
               state   <= WAIT_DRQ;
            end
            FINISH: begin
               done    <= 1'b0;
               aborted <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // Byte boundary: abort only takes effect here, never inside a byte.
         if (byte_done) begin
            addr_q  <= addr_q + ADDR_W'(1);
            cnt_q   <= cnt_q - LEN_W'(1);
            burst_q <= burst_q - 2'd1;
            if (last_byte) begin
               state   <= FINISH;
               done    <= 1'b1;
               aborted <= 1'b0;
            end else if (more_in_burst && !abort) begin
               if (!dir_q) begin
                  state   <= MEM_RD;
                  mem_req <= 1'b1;
                  mem_we  <= 1'b0;
               end else begin
                  state     <= TUBE_RD;
                  tube_cs_b <= 1'b0;
                  tube_rdnw <= 1'b1;
               end
            end else if (abort) begin
               state   <= FINISH;
               done    <= 1'b1;
               aborted <= 1'b1;
            end else begin
               state <= SETTLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_tube_r3_dma_ctrl.sv
// tb/tb_tube_r3_dma_ctrl.sv - directed bench for tube_r3_dma_ctrl.
// Burst expectations follow TUBE_DMA_TWO_BYTE_EN.
module tb_tube_r3_dma_ctrl;

`ifdef TUBE_DMA_TWO_BYTE_EN
   localparam int BURST = 2;
`else
   localparam int BURST = 1;
`endif

   logic        clk = 1'b0;
   logic        h_rst_b;
   logic        start, dir, abort, drq, two_byte_mode;
   logic [15:0] start_addr, length;
   logic        tube_cs_b, tube_rdnw;
   logic [2:0]  tube_addr;
   logic [7:0]  tube_wdata, tube_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        busy, done, aborted;
   logic [15:0] remaining;

   always #5 clk = ~clk;

   tube_r3_dma_ctrl #(.ADDR_W(16), .LEN_W(16)) dut (
      .clk(clk), .h_rst_b(h_rst_b), .start(start), .dir(dir),
      .start_addr(start_addr), .length(length), .abort(abort), .drq(drq),
      .two_byte_mode(two_byte_mode), .tube_cs_b(tube_cs_b), .tube_addr(tube_addr),
      .tube_rdnw(tube_rdnw), .tube_wdata(tube_wdata), .tube_rdata(tube_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy), .done(done),
      .aborted(aborted), .remaining(remaining)
   );

   int          total = 0;
   int          bad = 0;
   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          act_cnt = 0;
   int          done_cnt = 0;
   logic [7:0]  rd_cnt = 8'h00;
   logic        last_aborted = 1'b0;
   logic [15:0] last_remaining = 16'h0;
   logic [7:0]  tw_q[$];
   logic [15:0] ma_q[$];
   logic        mw_q[$];
   logic [7:0]  md_q[$];

   // Memory and Tube models: memory data is a function of address, Tube read data steps per read.
   assign mem_ack    = mem_req && (wait_cnt >= ack_delay);
   assign mem_rdata  = mem_addr[7:0] ^ 8'h5A;
   assign tube_rdata = 8'h40 + rd_cnt;

   always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

   always @(negedge clk) begin
      if (mem_req && mem_ack) begin
         ma_q.push_back(mem_addr);
         mw_q.push_back(mem_we);
         md_q.push_back(mem_wdata);
      end
      if (!tube_cs_b) begin
         if (tube_rdnw) rd_cnt = rd_cnt + 8'd1;
         else tw_q.push_back(tube_wdata);
      end
      if (!tube_cs_b || mem_req) act_cnt++;
      if (done) begin
         done_cnt++;
         last_aborted   = aborted;
         last_remaining = remaining;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic kick(input logic d, input logic [15:0] a, input logic [15:0] l);
      @(negedge clk);
      dir = d; start_addr = a; length = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget, input string tag);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, done_cnt - d0, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int q0, t0, d0, a0, ex;
      logic [7:0] r0, rb;
      logic [7:0] t1_data [3] = '{8'h5A, 8'h5B, 8'h58};
      h_rst_b = 1'b0; start = 1'b0; dir = 1'b0; abort = 1'b0; drq = 1'b0;
      two_byte_mode = 1'b0; start_addr = 16'h0; length = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_cs_b", tube_cs_b, 1);
      chk("rst_rdnw", tube_rdnw, 1);
      chk("rst_wdata", tube_wdata, 0);
      chk("rst_taddr", tube_addr, 5);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_remaining", remaining, 0);
      h_rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // memory to tube, 3 bytes, drq held high
      drq = 1'b1; ack_delay = 0;
      q0 = ma_q.size(); t0 = tw_q.size(); d0 = done_cnt;
      kick(1'b0, 16'h1000, 16'd3);
      chk("t1_busy", busy, 1);
      @(negedge clk);
      chk("t1_first_strobe", mem_req, 1);
      wait_done(d0, 40, "t1_done");
      chk("t1_nmem", ma_q.size() - q0, 3);
      chk("t1_ntube", tw_q.size() - t0, 3);
      if (ma_q.size() - q0 == 3 && tw_q.size() - t0 == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk("t1_addr", ma_q[q0+i], 32'h1000 + i);
            chk("t1_we", mw_q[q0+i], 0);
            chk("t1_tdata", tw_q[t0+i], t1_data[i]);
         end
      end
      chk("t1_aborted", last_aborted, 0);
      chk("t1_remaining", last_remaining, 0);
      chk("t1_idle", busy, 0);

      // tube to memory, 4 bytes, drq pulsed per burst
      drq = 1'b0; two_byte_mode = 1'b1;
      q0 = ma_q.size(); d0 = done_cnt; r0 = rd_cnt;
      kick(1'b1, 16'h2000, 16'd4);
      for (int p = 0; p < 4 / BURST; p++) begin
         rb = rd_cnt;
         drq = 1'b1;
         @(negedge clk);
         drq = 1'b0;
         chk("t2_strobe", tube_cs_b, 0);
         repeat (7) @(negedge clk);
         chk("t2_reads_per_drq", rd_cnt - rb, BURST);
      end
      wait_done(d0, 20, "t2_done");
      two_byte_mode = 1'b0;
      chk("t2_nmem", ma_q.size() - q0, 4);
      if (ma_q.size() - q0 == 4) begin
         for (int i = 0; i < 4; i++) begin
            ex = 32'h40 + r0 + i + 1;
            chk("t2_addr", ma_q[q0+i], 32'h2000 + i);
            chk("t2_we", mw_q[q0+i], 1);
            chk("t2_wdata", md_q[q0+i], ex[7:0]);
         end
      end
      chk("t2_remaining", last_remaining, 0);

      // zero-length transfer
      drq = 1'b1; a0 = act_cnt;
      kick(1'b0, 16'h4000, 16'd0);
      chk("t3_done", done, 1);
      @(negedge clk);
      chk("t3_done_clear", done, 0);
      chk("t3_busy_clear", busy, 0);
      repeat (3) @(negedge clk);
      chk("t3_no_activity", act_cnt - a0, 0);

      // address wrap
      q0 = ma_q.size(); t0 = tw_q.size(); d0 = done_cnt;
      kick(1'b0, 16'hFFFF, 16'd2);
      wait_done(d0, 30, "t4_done");
      chk("t4_nmem", ma_q.size() - q0, 2);
      if (ma_q.size() - q0 == 2 && tw_q.size() - t0 == 2) begin
         chk("t4_addr0", ma_q[q0], 16'hFFFF);
         chk("t4_addr1", ma_q[q0+1], 16'h0000);
         chk("t4_tdata0", tw_q[t0], 8'hA5);
         chk("t4_tdata1", tw_q[t0+1], 8'h5A);
      end

      // abort during a slow memory read
      ack_delay = 3;
      q0 = ma_q.size(); t0 = tw_q.size(); d0 = done_cnt;
      kick(1'b0, 16'h3000, 16'd4);
      @(negedge clk);
      chk("t5_in_mem_rd", mem_req, 1);
      abort = 1'b1;
      wait_done(d0, 30, "t5_done");
      abort = 1'b0;
      chk("t5_nmem", ma_q.size() - q0, 1);
      chk("t5_ntube", tw_q.size() - t0, 1);
      if (tw_q.size() - t0 == 1) chk("t5_tdata", tw_q[t0], 8'h5A);
      chk("t5_aborted", last_aborted, 1);
      chk("t5_remaining", last_remaining, 3);

      // abort landing on the last byte is a normal completion
      q0 = ma_q.size(); t0 = tw_q.size(); d0 = done_cnt;
      kick(1'b0, 16'h3010, 16'd1);
      @(negedge clk);
      abort = 1'b1;
      wait_done(d0, 30, "t5b_done");
      abort = 1'b0;
      chk("t5b_ntube", tw_q.size() - t0, 1);
      if (tw_q.size() - t0 == 1) chk("t5b_tdata", tw_q[t0], 8'h4A);
      chk("t5b_aborted", last_aborted, 0);
      chk("t5b_remaining", last_remaining, 0);
      ack_delay = 0;

      // asynchronous reset during a tube strobe
      d0 = done_cnt;
      kick(1'b0, 16'h0500, 16'd2);
      repeat (2) @(negedge clk);
      chk("t6_strobe_low", tube_cs_b, 0);
      #2 h_rst_b = 1'b0;
      #1;
      chk("t6_cs_async", tube_cs_b, 1);
      chk("t6_busy_async", busy, 0);
      chk("t6_req_async", mem_req, 0);
      @(negedge clk);
      h_rst_b = 1'b1;
      @(negedge clk);
      chk("t6_no_done", done_cnt - d0, 0);
      q0 = ma_q.size(); t0 = tw_q.size(); d0 = done_cnt;
      kick(1'b0, 16'h0105, 16'd1);
      wait_done(d0, 30, "t6_after_done");
      chk("t6_nmem", ma_q.size() - q0, 1);
      if (ma_q.size() - q0 == 1 && tw_q.size() - t0 == 1) begin
         chk("t6_addr", ma_q[q0], 16'h0105);
         chk("t6_tdata", tw_q[t0], 8'h5F);
      end
      chk("t6_aborted", last_aborted, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tube_r3_dma_ctrl.md
# tube_r3_dma_ctrl

Parasite-side block-transfer sequencer for Tube register 3. It sits between the parasite CPU memory bus and the parasite port of the Tube ULA. On a start command it moves a block of bytes between parasite memory and the register-3 FIFO. Transfers are paced by the Tube DRQ output, so the coprocessor does not need to service PNMI for every byte.

## Interface
Parameters:
- ADDR_W, 16, parasite memory address width
- LEN_W, 16, transfer length counter width

Ports:
- clk  in  1  parasite system clock; all state changes on rising edge
- h_rst_b  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; accepted only in IDLE
- dir  in  1  0 = memory→tube (parasite writes reg 3); 1 = tube→memory (parasite reads reg 3); sampled with start
- start_addr  in  ADDR_W  first memory address; sampled with start
- length  in  LEN_W  byte count; 0 means empty transfer; sampled with start
- abort  in  1  level; stop at the next safe point
- drq  in  1  Tube DMA request (M=1 pacing)
- two_byte_mode  in  1  mirror of the Tube V flag
- tube_cs_b  out  1  Tube chip select, active-low
- tube_addr  out  3  Tube register address; constant 3'h5
- tube_rdnw  out  1  1 = read reg 3, 0 = write reg 3
- tube_wdata  out  8  write data to Tube
- tube_rdata  in  8  read data from Tube
- mem_req  out  1  memory request
- mem_we  out  1  1 = memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data
- mem_ack  in  1  memory completion; may be high in the first request cycle
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of transfer
- aborted  out  1  valid with done; 1 if the transfer was terminated by abort
- remaining  out  LEN_W  bytes not yet transferred

## Operation
- Holding registers: addr_q, cnt_q, dir_q, and an 8-bit byte buffer buf_q.
- States: IDLE, WAIT_DRQ, MEM_RD, TUBE_WR, TUBE_RD, MEM_WR, SETTLE, FINISH.
- IDLE + start:
  - length==0 → FINISH.
  - Otherwise load addr_q/cnt_q/dir_q, set burst_q = 2 if two_byte_mode else 1, go to WAIT_DRQ.
- IDLE ignores start while busy is high.
- WAIT_DRQ:
  - abort → FINISH with aborted=1.
  - drq=1 → MEM_RD (dir 0) or TUBE_RD (dir 1).
  - Otherwise stay.
- dir 0 byte sequence: MEM_RD (mem_req=1, mem_we=0; on mem_ack latch mem_rdata into buf_q) → TUBE_WR (one cycle, tube_cs_b=0, tube_rdnw=0, tube_wdata=buf_q).
- dir 1 byte sequence: TUBE_RD (one cycle, tube_cs_b=0, tube_rdnw=1; latch tube_rdata into buf_q at end of cycle) → MEM_WR (mem_req=1, mem_we=1, mem_wdata=buf_q, held until mem_ack).
- After each byte:
  - addr_q += 1, wrapping at 2^ADDR_W.
  - cnt_q -= 1.
  - burst_q -= 1.
- After a byte, next state:
  - cnt_q==0 → FINISH.
  - burst_q!=0 and no abort → next byte of the same burst, without re-sampling drq.
  - Else → SETTLE.
- SETTLE: exactly one cycle, then WAIT_DRQ. This lets DRQ reflect the updated FIFO state.
- FINISH: done=1 for one cycle, then IDLE.
- Abort:
  - Never splits a byte: an in-flight memory access completes to mem_ack, and the paired Tube access is still issued.
  - Takes effect at the byte boundary: → FINISH with aborted=1.
  - If the abort lands on the last byte (cnt_q reaches 0), aborted=0.
- two_byte_mode is sampled only at burst start. A final odd byte in two-byte mode is a one-byte burst.

## Timing
- Reset values:
  - tube_cs_b=1, tube_rdnw=1, tube_wdata=0, tube_addr=3'h5.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, aborted=0, remaining=0.
  - State IDLE.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous). The partial transfer is lost.
- start → busy high in the next cycle.
- drq seen in WAIT_DRQ → first strobe (mem_req or tube_cs_b) in the next cycle.
- Tube strobe width is exactly 1 clk. At least 1 clk separates consecutive tube strobes.
- Minimum per byte: 2 clk (mem_ack in the first cycle).
- Minimum per one-byte burst: 4 clk (WAIT_DRQ, byte, byte, SETTLE). A two-byte burst saves one SETTLE and one WAIT_DRQ.
- All outputs are registered. remaining equals cnt_q.

## Configuration
- TUBE_DMA_TWO_BYTE_EN defined: two_byte_mode honoured as described above.
- Not defined: two_byte_mode is ignored and burst_q is always 1. Every byte is preceded by SETTLE and a drq sample.

## Test plan
- Reset, then start dir=0, addr=0x1000, len=3, drq tied 1 → mem reads at 0x1000..0x1002; three tube writes with matching data; done pulse; remaining=0; aborted=0.
- dir=1, len=4, two_byte_mode=1, drq pulsed per burst → exactly two tube reads per drq; mem writes at addr..addr+3; one SETTLE between bursts.
- len=0 start → done on 2nd cycle; no tube_cs_b or mem_req activity.
- Addr 0xFFFF, len=2 → second access at 0x0000 (wrap).
- abort raised during MEM_RD with mem_ack delayed 3 cycles → access completes, paired tube write is issued, done with aborted=1, remaining=len-1.
- h_rst_b asserted while tube_cs_b=0 → tube_cs_b=1, busy=0 without waiting for clk. A later start runs normally.
